pixel_write_sink: RTL

//  Receiving end of the datapath pixel stream (x_draw, y_draw, outColour, writeEn).
//  - Captures every write-enabled pixel and drops any pixel outside the screen.
//  - Packs 24-bit colour to 9-bit RGB333 and computes the linear framebuffer address.
//  - Buffers pixels in a FIFO and drains them to the framebuffer write port under a valid/ready handshake.
//  - Decouples the one-pixel-per-cycle draw stream from a framebuffer that stalls (e.g. scanout arbitration).

---
 rtl/pixel_write_sink.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pixel_write_sink.sv
// pixel_write_sink
//   Receiving end of the datapath pixel stream. Each write-enabled pixel is
//   registered. Off-screen pixels are dropped and counted. On-screen pixels
//   are packed to RGB333, addressed linearly (y*XRES + x) and queued in a
//   FIFO. The queue drains to the framebuffer write port through a
//   valid/ready output register, so the source never sees backpressure.
//
// Ports
//   clk, reset           system clock; asynchronous active-high reset
//   x_draw, y_draw       pixel coordinates (8 bits each)
//   outColour            24-bit colour {R,G,B}
//   writeEn              pixel valid this cycle
//   fb_addr, fb_data     framebuffer address / packed RGB333 colour
//   fb_we, fb_ready      write valid / framebuffer accept
//   fifo_count           entries held in the FIFO (output register excluded)
//   idle                 nothing buffered and nothing in flight
//   clip_count           saturating count of off-screen pixels
//   overflow             sticky: a pixel was lost to a full FIFO
module pixel_write_sink #(
  parameter int XRES       = 160,
  parameter int YRES       = 120,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    x_draw,
  input  logic [7:0]                    y_draw,
  input  logic [23:0]                   outColour,
  input  logic                          writeEn,
  output logic [ADDR_W-1:0]             fb_addr,
  output logic [8:0]                    fb_data,
  output logic                          fb_we,
  input  logic                          fb_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          idle,
  output logic [7:0]                    clip_count,
  output logic                          overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_W + 9;   // {addr, data}

  logic          w_offscreen;
  logic [ADDR_W-1:0] w_addr;
  logic [8:0]    w_data;
  logic          w_unused_colour;

  logic          w_full;
  logic          w_empty;
  logic          w_load;
  logic          w_pop;
  logic          w_push;
  logic          w_lost;

  logic          r_s1_valid;
  logic [EW-1:0] r_s1_entry;
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_clip;
  logic          r_ovf;
  logic          r_fb_we;
  logic [EW-1:0] r_fb_entry;

  // Input decode
  always_comb begin
    w_offscreen = (int'(x_draw) >= XRES) || (int'(y_draw) >= YRES);
    w_addr      = ADDR_W'(y_draw) * ADDR_W'(XRES) + ADDR_W'(x_draw);
    w_data      = {outColour[23:21], outColour[15:13], outColour[7:5]};
  end

  // Low colour bits are discarded by the RGB333 packing.
  assign w_unused_colour = ^{outColour[20:16], outColour[12:8], outColour[4:0]};

  // FIFO control. The output register reloads whenever it is empty or its
  // current write completes; a full FIFO still accepts a push on a pop cycle.
  always_comb begin
    w_full  = (r_count == CW'(FIFO_DEPTH));
    w_empty = (r_count == '0);
    w_load  = !r_fb_we || fb_ready;
    w_pop   = w_load && !w_empty;
    w_push  = r_s1_valid && (!w_full || w_pop);
    w_lost  = r_s1_valid && w_full && !w_pop;
  end

  // Stage 1: registered input with clipping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_entry <= '0;
      r_clip     <= '0;
    end else begin
      r_s1_valid <= 1'b0;
      if (writeEn) begin
        if (w_offscreen) begin
          if (r_clip != 8'hFF) r_clip <= r_clip + 8'd1;
        end else begin
          r_s1_valid <= 1'b1;
          r_s1_entry <= {w_addr, w_data};
        end
      end
    end
  end

  // FIFO storage needs no reset: contents are only read while r_count > 0.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_s1_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_lost) r_ovf <= 1'b1;
    end
  end

  // Output register: holds address/data stable while stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fb_we    <= 1'b0;
      r_fb_entry <= '0;
    end else if (w_load) begin
      r_fb_we <= w_pop;
      if (w_pop) r_fb_entry <= r_mem[r_rd_ptr];
    end
  end

  assign fb_we      = r_fb_we;
  assign fb_addr    = r_fb_entry[EW-1:9];
  assign fb_data    = r_fb_entry[8:0];
  assign fifo_count = r_count;
  assign idle       = w_empty && !r_s1_valid && !r_fb_we;
  assign clip_count = r_clip;
  assign overflow   = r_ovf;

endmodule
